// File: rtl/eq_limiter_pkg.sv
// eq_limiter_pkg: shared constants, FSM state type and helpers for the
// stereo output limiter (eq_out_limiter) and its per-channel multiplier.
package eq_limiter_pkg;

  localparam int          SAMPLE_W   = 32;        // width handled by abs_sat
  localparam int          NUM_LANES  = 2;         // lane 0 = left, lane 1 = right
  localparam logic [15:0] GAIN_UNITY = 16'h8000;  // 1.0 in Q1.15
  localparam logic [15:0] GAIN_MIN   = 16'h0100;  // attack floor

  typedef enum logic [2:0] {
    IDLE,
    PEAK,
    ENV,
    APPLY,
    OUT
  } lim_state_e;

  // |x| with the single unrepresentable case (-2^(W-1)) pinned to max positive.
  function automatic logic [SAMPLE_W-1:0] abs_sat(input logic [SAMPLE_W-1:0] x);
    if (x == {1'b1, {(SAMPLE_W-1){1'b0}}})
      return {1'b0, {(SAMPLE_W-1){1'b1}}};
    return x[SAMPLE_W-1] ? -x : x;
  endfunction

endpackage

// File: rtl/sat_mul_q15.sv
// sat_mul_q15: one channel of the limiter output stage.
//   y = (x * gain) >>> (GAIN_W-1), then clamped to [-THRESH, +THRESH].
// Ports:
//   x     in  DATA_W  signed sample
//   gain  in  GAIN_W  unsigned Q1.15 gain
//   y     out DATA_W  scaled and clamped sample
//   clip  out 1       clamp engaged (either rail)
module sat_mul_q15 #(
  parameter int                DATA_W = 32,
  parameter int                GAIN_W = 16,
  parameter logic [DATA_W-1:0] THRESH = 32'h4000_0000
) (
  input  logic [DATA_W-1:0] x,
  input  logic [GAIN_W-1:0] gain,
  output logic [DATA_W-1:0] y,
  output logic              clip
);

  // One spare bit so the unsigned gain stays positive inside a signed product.
  localparam int PW = DATA_W + GAIN_W + 1;

  logic signed [PW-1:0] prod, shifted, pos_lim, neg_lim;
  logic                 hi, lo;

  assign prod    = $signed({{(GAIN_W+1){x[DATA_W-1]}}, x}) *
                   $signed({{DATA_W{1'b0}}, 1'b0, gain});
  assign shifted = prod >>> (GAIN_W - 1);
  assign pos_lim = $signed({{(PW-DATA_W){1'b0}}, THRESH});
  assign neg_lim = -pos_lim;

  assign hi   = shifted > pos_lim;
  assign lo   = shifted < neg_lim;
  assign clip = hi | lo;
  assign y    = hi ? pos_lim[DATA_W-1:0] :
                lo ? neg_lim[DATA_W-1:0] : shifted[DATA_W-1:0];

endmodule

// File: rtl/eq_out_limiter.sv
// eq_out_limiter: stereo peak limiter between the equalizer outputs and the
// Audio_Controller write port. A shared gain envelope (fast attack, slow
// release) scales both channels, which are then hard-clamped to +/-THRESH.
// Each processed pair is written once, when out_allowed is high.
//
// Ports:
//   CLOCK_50     in   system clock
//   reset        in   synchronous, active-high
//   in_valid     in   equalizer pair available
//   l_in, r_in   in   DATA_W signed samples
//   in_ready     out  pair can be accepted (IDLE and no write this cycle)
//   out_allowed  in   controller audio_out_allowed
//   l_out, r_out out  processed samples, held until written
//   out_write    out  one-cycle write strobe
//   gain_mon     out  current Q1.15 gain
//   limiting     out  gain below unity (registered)
//   clip_count   out  16-bit saturating clamp-event count
//                     (only when LIMITER_CLIP_CNT_EN is defined)
//
// DATA_W and GAIN_W are tied to the package helper (32-bit abs_sat) and the
// 16-bit Q1.15 gain constants.
module eq_out_limiter
  import eq_limiter_pkg::*;
#(
  parameter int                DATA_W        = 32,
  parameter int                GAIN_W        = 16,
  parameter logic [DATA_W-1:0] THRESH        = 32'h4000_0000,
  parameter int                ATTACK_SHIFT  = 4,
  parameter int                RELEASE_SHIFT = 10
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] l_in,
  input  logic [DATA_W-1:0] r_in,
  output logic              in_ready,
  input  logic              out_allowed,
  output logic [DATA_W-1:0] l_out,
  output logic [DATA_W-1:0] r_out,
  output logic              out_write,
  output logic [GAIN_W-1:0] gain_mon,
  output logic              limiting
`ifdef LIMITER_CLIP_CNT_EN
  ,
  output logic [15:0]       clip_count
`endif
);

  localparam int PROD_W = DATA_W + GAIN_W;

  lim_state_e state_q, state_d;

  logic [NUM_LANES-1:0][DATA_W-1:0] samp_q, y;
  logic [NUM_LANES-1:0]             clip;
  logic [DATA_W-1:0]                abs_l, abs_r, peak_q;
  logic [GAIN_W-1:0]                gain_q, gain_old, gain_env, gain_dec, gain_inc;
  logic [PROD_W-1:0]                env_prod, scaled;
  logic                             accept;

  // A pair offered in the write cycle is refused; it gets in one cycle later.
  assign in_ready = (state_q == IDLE) && !out_write;
  assign accept   = in_ready && in_valid;
  assign gain_mon = gain_q;

  // ---------------- FSM ----------------
  always_ff @(posedge CLOCK_50) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = PEAK;
      PEAK:    state_d = ENV;
      ENV:     state_d = APPLY;
      APPLY:   state_d = OUT;
      OUT:     if (out_allowed) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- envelope ----------------
  assign abs_l = abs_sat(samp_q[0]);
  assign abs_r = abs_sat(samp_q[1]);

  always_comb begin
    env_prod = {{GAIN_W{1'b0}}, peak_q} * {{DATA_W{1'b0}}, gain_q};
    scaled   = env_prod >> (GAIN_W - 1);
    gain_dec = gain_q >> ATTACK_SHIFT;
    gain_inc = (GAIN_UNITY - gain_q) >> RELEASE_SHIFT;
    gain_env = gain_q;
    if (scaled > {{GAIN_W{1'b0}}, THRESH}) begin
      gain_env = gain_q - gain_dec;
      if (gain_env < GAIN_MIN) gain_env = GAIN_MIN;
    end else if (gain_q < GAIN_UNITY) begin
      // release step never rounds to zero, so unity is always reached
      gain_env = gain_q + ((gain_inc == '0) ? {{(GAIN_W-1){1'b0}}, 1'b1} : gain_inc);
    end
  end

  // ---------------- per-channel scale/clamp ----------------
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    sat_mul_q15 #(
      .DATA_W (DATA_W),
      .GAIN_W (GAIN_W),
      .THRESH (THRESH)
    ) u_mul (
      .x    (samp_q[i]),
      .gain (gain_old),
      .y    (y[i]),
      .clip (clip[i])
    );
  end

  // ---------------- datapath ----------------
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      samp_q    <= '0;
      peak_q    <= '0;
      gain_q    <= GAIN_UNITY;
      gain_old  <= GAIN_UNITY;
      l_out     <= '0;
      r_out     <= '0;
      out_write <= 1'b0;
      limiting  <= 1'b0;
    end else begin
      out_write <= 1'b0;
      case (state_q)
        IDLE:  if (accept) samp_q <= {r_in, l_in};
        PEAK:  peak_q <= (abs_l > abs_r) ? abs_l : abs_r;
        ENV: begin
          // outputs of this pair use the gain in force before the update
          gain_old <= gain_q;
          gain_q   <= gain_env;
          limiting <= (gain_env != GAIN_UNITY);
        end
        APPLY: begin
          l_out <= y[0];
          r_out <= y[1];
        end
        OUT:   if (out_allowed) out_write <= 1'b1;
        default: ;
      endcase
    end
  end

`ifdef LIMITER_CLIP_CNT_EN
  always_ff @(posedge CLOCK_50) begin
    if (reset)
      clip_count <= '0;
    else if (state_q == APPLY && (|clip) && clip_count != 16'hFFFF)
      clip_count <= clip_count + 16'd1;
  end
`else
  logic clip_unused;
  assign clip_unused = |clip;
`endif

endmodule

// File: tb/tb_eq_out_limiter.sv
module tb_eq_out_limiter;

  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b1, in_valid = 1'b0, out_allowed = 1'b0;
  logic [31:0] l_in = '0, r_in = '0;
  logic [31:0] l_out, r_out;
  logic        in_ready, out_write, limiting;
  logic [15:0] gain_mon;
`ifdef LIMITER_CLIP_CNT_EN
  logic [15:0] clip_count;
`endif

  eq_out_limiter dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .in_valid    (in_valid),
    .l_in        (l_in),
    .r_in        (r_in),
    .in_ready    (in_ready),
    .out_allowed (out_allowed),
    .l_out       (l_out),
    .r_out       (r_out),
    .out_write   (out_write),
    .gain_mon    (gain_mon),
    .limiting    (limiting)
`ifdef LIMITER_CLIP_CNT_EN
    ,
    .clip_count  (clip_count)
`endif
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int vectors = 0, miscompares = 0;

  // reference model state
  localparam longint TH   = 64'h4000_0000;
  localparam longint UNIT = 32768;
  longint g_m = UNIT;
  int     clip_m = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  function automatic longint absv(input logic [31:0] x);
    longint v = longint'($signed(x));
    if (v < 0) v = -v;
    if (v > 64'h7FFF_FFFF) v = 64'h7FFF_FFFF;
    return v;
  endfunction

  function automatic longint clampv(input longint v);
    if (v > TH)  return TH;
    if (v < -TH) return -TH;
    return v;
  endfunction

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; out_allowed = 1'b0;
    tick(); tick();
    check("rst_gain", 64'(gain_mon), 64'h8000);
    check("rst_write", 64'(out_write), 0);
    check("rst_ready", 64'(in_ready), 1);
    check("rst_limiting", 64'(limiting), 0);
    check("rst_lout", 64'(l_out), 0);
    check("rst_rout", 64'(r_out), 0);
    reset = 1'b0;
    g_m = UNIT; clip_m = 0;
  endtask

  // One pair through the limiter. hold = cycles out_allowed stays low once
  // the pair sits waiting; busy_pulse toggles in_valid during that wait.
  task automatic run_pair(input logic [31:0] l, input logic [31:0] r,
                          input int hold, input bit busy_pulse);
    longint pk, yl, yr, inc;
    logic [31:0] el, er;
    int cyc;
    // model: peak and outputs use the pre-update gain
    pk = (absv(l) > absv(r)) ? absv(l) : absv(r);
    yl = (longint'($signed(l)) * g_m) >>> 15;
    yr = (longint'($signed(r)) * g_m) >>> 15;
    if (yl > TH || yl < -TH || yr > TH || yr < -TH) if (clip_m < 65535) clip_m++;
    yl = clampv(yl); yr = clampv(yr);
    el = yl[31:0]; er = yr[31:0];
    if ((pk * g_m) / UNIT > TH) begin
      g_m = g_m - g_m / 16;
      if (g_m < 256) g_m = 256;
    end else if (g_m < UNIT) begin
      inc = (UNIT - g_m) / 1024;
      if (inc < 1) inc = 1;
      g_m = g_m + inc;
    end

    check("ready_idle", 64'(in_ready), 1);
    l_in = l; r_in = r; in_valid = 1'b1; out_allowed = (hold == 0);
    tick();
    in_valid = 1'b0; l_in = $urandom; r_in = $urandom;
    cyc = 0;
    while (out_write !== 1'b1 && cyc < 200) begin
      if (cyc == 3 + hold) begin
        out_allowed = 1'b1; in_valid = 1'b0;
      end else if (busy_pulse && cyc >= 3 && cyc < 3 + hold) begin
        check("busy_ready", 64'(in_ready), 0);
        check("busy_lout", 64'(l_out), 64'(el));
        in_valid = (cyc % 2 == 1);
      end
      tick(); cyc++;
    end
    check("latency", 64'(cyc), 64'(4 + hold));
    check("lout", 64'(l_out), 64'(el));
    check("rout", 64'(r_out), 64'(er));
    check("gain", 64'(gain_mon), 64'(g_m));
    check("limiting", 64'(limiting), 64'(g_m != UNIT));
    check("ready_in_write", 64'(in_ready), 0);
    // offer a pair exactly in the write cycle: must be refused
    in_valid = 1'b1; l_in = 32'h1234_5678; out_allowed = 1'b0;
    tick();
    in_valid = 1'b0;
    check("write_once", 64'(out_write), 0);
    check("same_cycle_reject", 64'(in_ready), 1);
  endtask

  task automatic reset_in_env();
    int writes;
    l_in = 32'h7FFF_FFFF; r_in = 32'h8000_0000; in_valid = 1'b1; out_allowed = 1'b1;
    tick();                 // captured, now PEAK
    in_valid = 1'b0;
    tick();                 // now ENV
    reset = 1'b1;
    tick();
    check("envrst_gain", 64'(gain_mon), 64'h8000);
    check("envrst_write", 64'(out_write), 0);
    check("envrst_ready", 64'(in_ready), 1);
    check("envrst_limiting", 64'(limiting), 0);
`ifdef LIMITER_CLIP_CNT_EN
    check("envrst_clipcnt", 64'(clip_count), 0);
`endif
    reset = 1'b0;
    g_m = UNIT; clip_m = 0;
    writes = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_write === 1'b1) writes++;
    end
    check("envrst_no_write", 64'(writes), 0);
  endtask

  initial begin
    logic [31:0] a, b;
    do_reset();

    // unity gain passthrough
    run_pair(32'h1000_0000, 32'h1000_0000, 0, 0);
    // full-scale left: clamp and first attack step
    run_pair(32'h7FFF_FFFF, 32'h0000_0000, 0, 0);
    // most negative sample: abs saturates, output clamps to -THRESH
    run_pair(32'h8000_0000, 32'h0000_0000, 0, 0);
    // quiet pairs: release steps
    for (int i = 0; i < 3; i++) run_pair(32'h0100_0000, 32'h0100_0000, 0, 0);
    // controller stalls for 20 cycles while equalizer keeps offering
    run_pair(32'h2000_0000, 32'hE000_0000, 20, 1);

    // randomized pairs over a spread of magnitudes
    for (int i = 0; i < 40; i++) begin
      a = $urandom; b = $urandom;
      a = 32'($signed(a) >>> $urandom_range(0, 8));
      b = 32'($signed(b) >>> $urandom_range(0, 8));
      run_pair(a, b, $urandom_range(0, 2), 0);
    end

    // guaranteed clipping pairs
    for (int i = 0; i < 3; i++) run_pair(32'h7FFF_FFFF, 32'h8000_0000, 0, 0);
`ifdef LIMITER_CLIP_CNT_EN
    check("clip_count", 64'(clip_count), 64'(clip_m));
`endif

    reset_in_env();
    run_pair(32'h0800_0000, 32'hF800_0000, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
